// File: rtl/cache_miss_ctrl.sv
// Controller for a two-cycle direct-mapped lookup cache: serves hits from the cache and
// handles misses by fetching the line from memory, refilling the cache, then responding.
module cache_miss_ctrl #(
    parameter int C_ADDR_WIDTH  = 32,
    parameter int C_INDEX_WIDTH = 10,
    parameter int C_TAG_WIDTH   = C_ADDR_WIDTH - C_INDEX_WIDTH,
    parameter int C_DATA_WIDTH  = 512,
    parameter int C_CNT_WIDTH   = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [C_ADDR_WIDTH-1:0]             req_addr,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic [C_DATA_WIDTH-1:0]             resp_data,
    output logic                                resp_hit,
    output logic                                cache_rd_en,
    output logic [C_INDEX_WIDTH-1:0]            cache_rd_addr,
    output logic [C_TAG_WIDTH-1:0]              cache_rd_din,
    input  logic                                cache_rd_valid,
    input  logic                                cache_rd_result,
    input  logic [C_DATA_WIDTH-1:0]             cache_rd_dout,
    output logic                                cache_wr_en,
    output logic [C_INDEX_WIDTH-1:0]            cache_wr_addr,
    output logic [C_DATA_WIDTH+C_TAG_WIDTH-1:0] cache_wr_data,
    output logic                                mem_rd_valid,
    input  logic                                mem_rd_ready,
    output logic [C_ADDR_WIDTH-1:0]             mem_rd_addr,
    input  logic                                mem_rsp_valid,
    output logic                                mem_rsp_ready,
    input  logic [C_DATA_WIDTH-1:0]             mem_rsp_data,
    output logic [C_CNT_WIDTH-1:0]              hit_cnt,
    output logic [C_CNT_WIDTH-1:0]              miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_FILL,
        S_RESP
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [C_ADDR_WIDTH-1:0]   addr_q;
    logic [C_DATA_WIDTH-1:0]   data_q;
    logic                      hit_q;
    logic [C_TAG_WIDTH-1:0]    tag;
    logic [C_INDEX_WIDTH-1:0]  index;

    assign tag   = addr_q[C_ADDR_WIDTH-1:C_INDEX_WIDTH];
    assign index = addr_q[C_INDEX_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next state defaults to the current state so every path assigns it and no latch forms.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (req_valid)      state_nxt = S_LOOKUP;
            S_LOOKUP:                       state_nxt = S_WAIT;
            S_WAIT:     if (cache_rd_valid) state_nxt = cache_rd_result ? S_RESP : S_MEM_REQ;
            S_MEM_REQ:  if (mem_rd_ready)   state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_rsp_valid)  state_nxt = S_FILL;
            S_FILL:                         state_nxt = S_RESP;
            S_RESP:     if (resp_ready)     state_nxt = S_IDLE;
            default:                        state_nxt = S_IDLE;
        endcase
    end

    // NOTE: these are a handful of flops, not a memory array, so they are cheap to reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            data_q   <= '0;
            hit_q    <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == S_IDLE && req_valid) addr_q <= req_addr;
            if (state == S_WAIT && cache_rd_valid) begin
                hit_q <= cache_rd_result;
                if (cache_rd_result) begin
                    data_q <= cache_rd_dout;
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + C_CNT_WIDTH'(1);
                end else begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + C_CNT_WIDTH'(1);
                end
            end
            if (state == S_MEM_WAIT && mem_rsp_valid) data_q <= mem_rsp_data;
        end
    end

    // Strobes and valids decode straight from state, so lookup and fill can never overlap.
    assign req_ready     = (state == S_IDLE);
    assign cache_rd_en   = (state == S_LOOKUP);
    assign cache_rd_addr = index;
    assign cache_rd_din  = tag;
    assign cache_wr_en   = (state == S_FILL);
    assign cache_wr_addr = index;
    assign cache_wr_data = {data_q, tag};
    assign mem_rd_valid  = (state == S_MEM_REQ);
    assign mem_rd_addr   = addr_q;
    assign mem_rsp_ready = (state == S_MEM_WAIT);
    assign resp_valid    = (state == S_RESP);
    assign resp_data     = data_q;
    assign resp_hit      = hit_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: the bench plays the cache and memory by hand, step by step,
// and checks every strobe, address and data word against hand-computed values.
module tb_cache_miss_ctrl;

    localparam int AW = 32;
    localparam int IW = 10;
    localparam int TW = AW - IW;
    localparam int DW = 512;
    localparam int CW = 4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_data;
    logic              resp_hit;
    logic              cache_rd_en;
    logic [IW-1:0]     cache_rd_addr;
    logic [TW-1:0]     cache_rd_din;
    logic              cache_rd_valid;
    logic              cache_rd_result;
    logic [DW-1:0]     cache_rd_dout;
    logic              cache_wr_en;
    logic [IW-1:0]     cache_wr_addr;
    logic [DW+TW-1:0]  cache_wr_data;
    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [AW-1:0]     mem_rd_addr;
    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [DW-1:0]     mem_rsp_data;
    logic [CW-1:0]     hit_cnt;
    logic [CW-1:0]     miss_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] line_a5 = {64{8'hA5}};
    logic [DW-1:0] line_3c = {64{8'h3C}};
    logic [DW-1:0] line_bp = {16{32'hDEADBEEF}};

    cache_miss_ctrl #(
        .C_ADDR_WIDTH (AW),
        .C_INDEX_WIDTH(IW),
        .C_DATA_WIDTH (DW),
        .C_CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_hit       (resp_hit),
        .cache_rd_en    (cache_rd_en),
        .cache_rd_addr  (cache_rd_addr),
        .cache_rd_din   (cache_rd_din),
        .cache_rd_valid (cache_rd_valid),
        .cache_rd_result(cache_rd_result),
        .cache_rd_dout  (cache_rd_dout),
        .cache_wr_en    (cache_wr_en),
        .cache_wr_addr  (cache_wr_addr),
        .cache_wr_data  (cache_wr_data),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_ready   (mem_rd_ready),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_ready  (mem_rsp_ready),
        .mem_rsp_data   (mem_rsp_data),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full request: the bench answers the lookup as hit or miss, optionally stalls the
    // memory request and the response, and checks each cycle of the expected timeline.
    task automatic run_req(input string name, input logic [AW-1:0] addr, input logic is_hit,
                           input logic [DW-1:0] line, input logic [IW-1:0] exp_idx,
                           input logic [TW-1:0] exp_tag, input int mem_stall, input int resp_stall);
        check({name, "/req_ready_idle"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();                                     // T1: LOOKUP
        req_valid = 1'b0;
        req_addr  = ~addr;
        check({name, "/rd_en_t1"}, cache_rd_en, 1'b1);
        check({name, "/rd_addr"}, cache_rd_addr, exp_idx);
        check({name, "/rd_din"}, cache_rd_din, exp_tag);
        check({name, "/req_ready_busy"}, req_ready, 1'b0);
        step();                                     // T2: WAIT, no result yet
        check({name, "/rd_en_t2"}, cache_rd_en, 1'b0);
        step();                                     // T3: result presented
        cache_rd_valid  = 1'b1;
        cache_rd_result = is_hit;
        cache_rd_dout   = is_hit ? line : ~line;
        step();                                     // T4
        cache_rd_valid  = 1'b0;
        cache_rd_result = 1'b0;
        cache_rd_dout   = '0;
        if (!is_hit) begin
            check({name, "/mem_rd_valid_t4"}, mem_rd_valid, 1'b1);
            check({name, "/mem_rd_addr"}, mem_rd_addr, addr);
            check({name, "/resp_valid_t4"}, resp_valid, 1'b0);
            mem_rd_ready  = 1'b0;
            mem_rsp_valid = 1'b1;                   // stray data before MEM_WAIT must be ignored
            mem_rsp_data  = ~line;
            for (int i = 0; i < mem_stall; i++) begin
                step();
                check({name, "/mem_rd_valid_stall"}, mem_rd_valid, 1'b1);
                check({name, "/mem_rd_addr_stall"}, mem_rd_addr, addr);
                check({name, "/rsp_ready_stall"}, mem_rsp_ready, 1'b0);
                check({name, "/req_ready_stall"}, req_ready, 1'b0);
            end
            mem_rsp_valid = 1'b0;
            mem_rd_ready  = 1'b1;
            step();                                 // MEM_WAIT
            mem_rd_ready = 1'b0;
            check({name, "/mem_rd_valid_done"}, mem_rd_valid, 1'b0);
            check({name, "/rsp_ready"}, mem_rsp_ready, 1'b1);
            step();                                 // still MEM_WAIT, no data
            check({name, "/rsp_ready_hold"}, mem_rsp_ready, 1'b1);
            check({name, "/wr_en_early"}, cache_wr_en, 1'b0);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = line;
            step();                                 // Tm+1: FILL
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            check({name, "/wr_en"}, cache_wr_en, 1'b1);
            check({name, "/rd_en_fill"}, cache_rd_en, 1'b0);
            check({name, "/wr_addr"}, cache_wr_addr, exp_idx);
            check({name, "/wr_data"}, cache_wr_data, {line, exp_tag});
            check({name, "/resp_valid_fill"}, resp_valid, 1'b0);
            step();                                 // Tm+2: RESP
            check({name, "/wr_en_done"}, cache_wr_en, 1'b0);
        end
        check({name, "/resp_valid"}, resp_valid, 1'b1);
        check({name, "/resp_hit"}, resp_hit, is_hit);
        check({name, "/resp_data"}, resp_data, line);
        resp_ready = 1'b0;
        req_valid  = 1'b1;                          // a new request must wait for the response
        req_addr   = addr;
        for (int i = 0; i < resp_stall; i++) begin
            step();
            check({name, "/resp_valid_bp"}, resp_valid, 1'b1);
            check({name, "/resp_data_bp"}, resp_data, line);
            check({name, "/resp_hit_bp"}, resp_hit, is_hit);
            check({name, "/req_ready_bp"}, req_ready, 1'b0);
            check({name, "/rd_en_bp"}, cache_rd_en, 1'b0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({name, "/resp_valid_end"}, resp_valid, 1'b0);
        check({name, "/req_ready_end"}, req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_addr        = '0;
        resp_ready      = 1'b0;
        cache_rd_valid  = 1'b0;
        cache_rd_result = 1'b0;
        cache_rd_dout   = '0;
        mem_rd_ready    = 1'b0;
        mem_rsp_valid   = 1'b0;
        mem_rsp_data    = '0;
        step();
        step();
        check("rst/resp_valid", resp_valid, 1'b0);
        check("rst/rd_en", cache_rd_en, 1'b0);
        check("rst/wr_en", cache_wr_en, 1'b0);
        check("rst/mem_rd_valid", mem_rd_valid, 1'b0);
        check("rst/rsp_ready", mem_rsp_ready, 1'b0);
        check("rst/resp_data", resp_data, '0);
        check("rst/hit_cnt", hit_cnt, 4'd0);
        check("rst/miss_cnt", miss_cnt, 4'd0);
        rst = 1'b0;
        step();
        check("rst/req_ready", req_ready, 1'b1);

        // Cold miss, then a hit on the same line.
        run_req("cold_miss", 32'h0000_0005, 1'b0, line_a5, 10'd5, 22'd0, 0, 0);
        check("cold_miss/miss_cnt", miss_cnt, 4'd1);
        check("cold_miss/hit_cnt", hit_cnt, 4'd0);
        run_req("repeat_hit", 32'h0000_0005, 1'b1, line_a5, 10'd5, 22'd0, 0, 0);
        check("repeat_hit/hit_cnt", hit_cnt, 4'd1);
        check("repeat_hit/miss_cnt", miss_cnt, 4'd1);

        // Conflict on index 5: tag 1 evicts tag 0, then tag 0 misses again.
        run_req("conflict", 32'h0000_0405, 1'b0, line_3c, 10'd5, 22'd1, 0, 0);
        check("conflict/miss_cnt", miss_cnt, 4'd2);
        run_req("reload", 32'h0000_0005, 1'b0, line_a5, 10'd5, 22'd0, 0, 0);
        check("reload/miss_cnt", miss_cnt, 4'd3);

        // Backpressure on memory request and response; wide address exercises the tag/index split.
        run_req("bp_miss", 32'h1234_5678, 1'b0, line_bp, 10'h278, 22'h48D15, 5, 10);
        check("bp_miss/miss_cnt", miss_cnt, 4'd4);
        run_req("bp_hit", 32'h1234_5678, 1'b1, line_bp, 10'h278, 22'h48D15, 0, 10);
        check("bp_hit/hit_cnt", hit_cnt, 4'd2);

        // Reset while waiting for memory data.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0077;
        step();
        req_valid = 1'b0;
        step();
        step();
        cache_rd_valid  = 1'b1;
        cache_rd_result = 1'b0;
        step();
        cache_rd_valid = 1'b0;
        mem_rd_ready   = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        check("mid_rst/in_mem_wait", mem_rsp_ready, 1'b1);
        check("mid_rst/miss_before", miss_cnt, 4'd5);
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = line_3c;
        step();
        check("mid_rst/rsp_ready", mem_rsp_ready, 1'b0);
        check("mid_rst/wr_en", cache_wr_en, 1'b0);
        check("mid_rst/resp_valid", resp_valid, 1'b0);
        check("mid_rst/hit_cnt", hit_cnt, 4'd0);
        check("mid_rst/miss_cnt", miss_cnt, 4'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst/wr_en", cache_wr_en, 1'b0);
            check("post_rst/resp_valid", resp_valid, 1'b0);
            check("post_rst/mem_rd_valid", mem_rd_valid, 1'b0);
            check("post_rst/req_ready", req_ready, 1'b1);
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;

        // Twenty hits against a 4-bit counter: it must stop at 15.
        for (int i = 1; i <= 20; i++) begin
            run_req("sat_hit", 32'h0000_0005, 1'b1, line_a5, 10'd5, 22'd0, 0, 0);
            if (i == 14) check("sat/hit_cnt_14", hit_cnt, 4'd14);
            if (i == 15) check("sat/hit_cnt_15", hit_cnt, 4'd15);
        end
        check("sat/hit_cnt_20", hit_cnt, 4'd15);
        check("sat/miss_cnt", miss_cnt, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
